issue_scheduler: RTL



---
 rtl/issue_scheduler.sv | 97 +++++++++
 1 files changed

// File: rtl/issue_scheduler.sv
// Age-ordered issue queue: applies completion wakeups to stored ops every cycle
// and issues the oldest fully-ready entry, compacting younger entries toward the head.
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 33
`endif

module issue_scheduler #(
  parameter int INST_WIDTH = `RENAMED_OP_SZ,
  parameter int DEPTH      = 4,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int IW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [29:0]           done_flags,
  input  logic [INST_WIDTH-1:0] in_instr,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [INST_WIDTH-1:0] out_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         count
);

  logic [INST_WIDTH-1:0] q      [DEPTH];
  logic [INST_WIDTH-1:0] merged [DEPTH];
  logic [INST_WIDTH-1:0] q_next [DEPTH];
  logic [INST_WIDTH-1:0] in_merged;
  logic [IW-1:0]         sel_idx;
  logic [IW-1:0]         wr_idx;
  logic                  fire;
  logic                  accept;

  // Tags 0 and 1 have no completion flag; tag t wakes on done_flags[t-2].
  function automatic logic [INST_WIDTH-1:0] wake(input logic [INST_WIDTH-1:0] op,
                                                 input logic [29:0] flags);
    logic [4:0] tag;
    wake = op;
    for (int i = 0; i < 4; i++) begin
      tag = op[13+5*i +: 5];
      if (tag >= 5'd2 && flags[tag - 5'd2])
        wake[4+i] = 1'b1;
    end
  endfunction

  always_comb begin
    for (int e = 0; e < DEPTH; e++)
      merged[e] = wake(q[e], done_flags);
    in_merged = wake(in_instr, done_flags);
  end

  // Scan from the youngest slot down so the last hit is the oldest eligible entry.
  always_comb begin
    out_valid = 1'b0;
    sel_idx   = '0;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      if (CW'(e) < count && merged[e][7:4] == 4'hF) begin
        out_valid = 1'b1;
        sel_idx   = IW'(e);
      end
    end
  end

  assign out_instr = out_valid ? merged[sel_idx] : '0;
  assign fire      = out_valid & out_ready;
  assign in_ready  = (count < CW'(DEPTH)) | fire;
  assign accept    = in_valid & in_ready;
  assign wr_idx    = IW'(count - CW'(fire));

  // Entries at or above the issued slot take their younger neighbour's merged op.
  always_comb begin
    int nx;
    for (int e = 0; e < DEPTH; e++) begin
      nx = (e + 1 < DEPTH) ? e + 1 : e;
      if (fire && IW'(e) >= sel_idx)
        q_next[e] = merged[nx];
      else
        q_next[e] = merged[e];
    end
    if (accept)
      q_next[wr_idx] = in_merged;
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++)
      q[e] <= q_next[e];
  end

  always_ff @(posedge clk) begin
    if (rst || flush)
      count <= '0;
    else
      count <= count + CW'(accept) - CW'(fire);
  end

endmodule
